// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding uart_top's tx_start/tx_data/tx_busy handshake
module uart_tx_fifo #(
  parameter  int DEPTH       = 16,
  parameter  int ACK_TIMEOUT = 8,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [LW-1:0] level_nxt;
  logic          wr_accept;
  logic          wr_drop;
  logic          pop;

  // flush outranks both a same-cycle write and a same-cycle pop
  assign wr_accept = wr_en && !full && !flush;
  assign wr_drop   = wr_en &&  full && !flush;
  assign pop       = (state == IDLE) && !empty && !tx_busy && !flush;

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (wr_accept && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !wr_accept) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (wr_drop) begin
          overflow <= 1'b1;
        end
        // tx_data only moves on a pop, so it stays put for the whole handshake
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          tx_data <= mem[rd_ptr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // a UART that never acknowledges costs one byte, not a stuck queue
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a behavioural UART responder
module tb_uart_tx_fifo;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 8;
  localparam int LW          = $clog2(DEPTH) + 1;
  localparam int HOLD        = 0;
  localparam int AUTO        = 1;
  localparam int LOW         = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       fl;
    int         lvl;
    logic       ov;
  } vec_t;

  vec_t       tbl[10];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         starts = 0;
  int         fall_cyc = -1;
  int         resp_mode = LOW;
  int         resp_cnt = 0;
  int         resp_len = 3;
  int         peak = 0;
  bit         chk_gap = 1'b0;
  logic [7:0] sent[$];
  int         start_cyc[$];
  logic [7:0] model[$];
  bit         model_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one clock: sample outputs after the edge, then let the UART responder react
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (int'(level) > peak) peak = int'(level);
    if (tx_start === 1'b1) begin
      if (chk_gap && fall_cyc >= 0) chk("b2b_gap", cyc - fall_cyc, 2);
      starts++;
      sent.push_back(tx_data);
      start_cyc.push_back(cyc);
      if (resp_mode == AUTO) begin
        tx_busy  = 1'b1;
        resp_cnt = resp_len;
      end
    end else if (resp_mode == AUTO && resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        chk("tx_data_hold", tx_data, sent[$]);
        tx_busy  = 1'b0;
        fall_cyc = cyc;
      end
    end
    if (resp_mode == HOLD) tx_busy = 1'b1;
    else if (resp_mode == LOW) tx_busy = 1'b0;
  endtask

  task automatic set_mode(input int m);
    resp_mode = m;
    resp_cnt  = 0;
    tx_busy   = (m == HOLD);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(empty && resp_cnt == 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({name, "_drain_timeout"}, 0, 1);
    repeat (ACK_TIMEOUT + 4) tick();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_level"}, level, 0);
    chk({p, "_empty"}, empty, 1);
    chk({p, "_full"}, full, 0);
    chk({p, "_overflow"}, overflow, 0);
    chk({p, "_tx_start"}, tx_start, 0);
    chk({p, "_tx_data"}, tx_data, 8'h00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    int c0;
    int n;
    int bad;

    tbl[0] = '{1'b1, 8'h01, 1'b0, 1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b0};
    tbl[2] = '{1'b1, 8'h02, 1'b0, 2, 1'b0};
    tbl[3] = '{1'b1, 8'h03, 1'b1, 0, 1'b0};
    tbl[4] = '{1'b1, 8'h04, 1'b0, 1, 1'b0};
    tbl[5] = '{1'b1, 8'h05, 1'b0, 2, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[7] = '{1'b1, 8'h06, 1'b0, 1, 1'b0};
    tbl[8] = '{1'b1, 8'h07, 1'b0, 2, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 2, 1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_busy = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;

    // table vectors with the UART held busy so nothing pops
    set_mode(HOLD);
    tick();
    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_data = tbl[i].d; flush = tbl[i].fl;
      tick();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_flags", i), {full, empty, overflow},
          {tbl[i].lvl == DEPTH, tbl[i].lvl == 0, tbl[i].ov});
    end
    wr_en = 1'b0; flush = 1'b0;
    set_mode(AUTO);
    sent.delete();
    wait_drain("tbl");
    chk("tbl_sent_count", sent.size(), 2);
    if (sent.size() == 2) begin
      chk("tbl_sent0", sent[0], 8'h06);
      chk("tbl_sent1", sent[1], 8'h07);
    end

    // single byte latency
    s0 = starts;
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("single_level_after_write", level, 1);
    chk("single_no_early_start", tx_start, 0);
    tick();
    chk("single_tx_start", tx_start, 1);
    chk("single_tx_data", tx_data, 8'hAA);
    chk("single_level_after_pop", level, 0);
    wait_drain("single");
    chk("single_start_count", starts - s0, 1);
    chk("single_level_end", level, 0);

    // burst of four
    sent.delete(); peak = 0; fall_cyc = -1; chk_gap = 1'b1; resp_len = 4;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'((i + 1) * 8'h11);
      tick();
    end
    wr_en = 1'b0;
    wait_drain("burst");
    chk_gap = 1'b0;
    chk("burst_count", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++)
      chk($sformatf("burst_byte%0d", i), sent[i], 8'((i + 1) * 8'h11));
    chk("burst_peak", (peak == 3 || peak == 4), 1);
    chk("burst_empty", empty, 1);

    // overflow: DEPTH+2 writes into a stalled queue
    set_mode(HOLD);
    tick();
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      if (i == DEPTH - 1) begin
        chk("ovf_full_at_depth", {full, level, overflow}, {1'b1, LW'(DEPTH), 1'b0});
      end
    end
    wr_en = 1'b0;
    chk("ovf_flags", {full, level, overflow}, {1'b1, LW'(DEPTH), 1'b1});
    set_mode(AUTO); resp_len = 3;
    sent.delete();
    wait_drain("ovf");
    chk("ovf_count", sent.size(), DEPTH);
    bad = 0;
    for (int i = 0; i < sent.size(); i++) if (sent[i] !== 8'(i)) bad++;
    chk("ovf_order_errors", bad, 0);
    chk("ovf_sticky", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovf_cleared_by_flush", overflow, 0);

    // flush with a byte in flight and a colliding write
    resp_len = 25; s0 = starts; sent.delete();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("flush_inflight_started", starts - s0, 1);
    chk("flush_level_before", level, 5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_state", {level, overflow, empty}, {LW'(0), 1'b0, 1'b1});
    wait_drain("flush");
    repeat (20) tick();
    chk("flush_start_count", starts - s0, 1);
    chk("flush_sent0", (sent.size() == 1) ? sent[0] : 8'hFF, 8'hA0);
    resp_len = 3;

    // acknowledge timeout: UART never raises busy
    set_mode(LOW); sent.delete(); start_cyc.delete();
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    c0 = cyc;
    wr_data = 8'h5B;
    tick();
    wr_en = 1'b0;
    wait_drain("timeout");
    chk("timeout_count", sent.size(), 2);
    if (sent.size() == 2) begin
      chk("timeout_byte0", sent[0], 8'h5A);
      chk("timeout_byte1", sent[1], 8'h5B);
      chk("timeout_first_latency", start_cyc[0] - c0, 1);
      chk("timeout_gap", start_cyc[1] - start_cyc[0], ACK_TIMEOUT + 2);
    end

    // reset while waiting for busy to fall, with three bytes queued
    set_mode(AUTO); resp_len = 30;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    repeat (4) tick();
    chk("rst_mid_level_before", level, 3);
    rst = 1'b1; resp_mode = LOW; resp_cnt = 0; tx_busy = 1'b0;
    tick();
    chk_reset("rst_mid");
    rst = 1'b0;
    s0 = starts;
    repeat (30) tick();
    chk("rst_mid_no_start", starts - s0, 0);
    resp_len = 3;

    // randomized rounds against a queue model; pointers keep wrapping between rounds
    model.delete(); model_ov = 1'b0;
    for (int r = 0; r < 40; r++) begin
      set_mode(HOLD);
      tick();
      n = $urandom_range(1, 22);
      bad = 0;
      for (int k = 0; k < n; k++) begin
        wr_en = ($urandom_range(0, 3) != 0);
        wr_data = 8'($urandom);
        flush = ($urandom_range(0, 19) == 0);
        if (flush) begin
          model.delete();
          model_ov = 1'b0;
        end else if (wr_en) begin
          if (model.size() == DEPTH) model_ov = 1'b1;
          else model.push_back(wr_data);
        end
        tick();
        if ({level, full, empty, overflow} !==
            {LW'(model.size()), model.size() == DEPTH, model.size() == 0, model_ov}) bad++;
      end
      wr_en = 1'b0; flush = 1'b0;
      chk($sformatf("rand%0d_status_errors", r), bad, 0);
      set_mode(AUTO);
      resp_len = $urandom_range(2, 5);
      sent.delete();
      wait_drain("rand");
      bad = (sent.size() == model.size()) ? 0 : 1;
      for (int i = 0; i < sent.size() && i < model.size(); i++) if (sent[i] !== model[i]) bad++;
      chk($sformatf("rand%0d_order_errors", r), bad, 0);
      chk($sformatf("rand%0d_overflow", r), overflow, model_ov);
      model.delete();
      if (model_ov) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_ov = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
